// File: rtl/pipelined_rca_adder_pkg.sv
// Package adder_pkg: defaults and helpers shared by the pipelined ripple-carry
// adder slice.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   stage_ctl_t                    : control part of a pipeline stage record
//   chunk_width()                  : bits added per stage (WIDTH / STAGES)
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Control fields carried by every stage. The width-dependent fields
  // (partial sum, delayed a/b_eff) are attached to this record in the top
  // level, where WIDTH is known.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// Interface pipelined_rca_adder_if: groups the input and output valid/ready
// channels of the pipelined adder.
//   input channel : in_valid, in_ready, a, b, ci, sub
//   output channel: out_valid, out_ready, s, co, ovf
//   modport master: the side that issues operations and consumes results
//   modport slave : the adder itself
interface pipelined_rca_adder_if #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );

endinterface

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// Module rca_chunk: combinational CHUNK-bit ripple-carry adder built from
// full-adder cells.
//   a, b  : chunk operands
//   ci    : carry into bit 0
//   s     : chunk sum
//   co    : carry out of the chunk MSB
//   c_msb : carry into the chunk MSB (used for signed overflow)
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co    = c_s[CHUNK];
  assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Module pipelined_rca_adder: pipelined ripple-carry adder/subtractor.
// Stage k adds operand chunk k plus the carry registered by stage k-1; the
// operand chunks not yet consumed and the result chunks already produced
// travel alongside, so the last stage presents a fully aligned result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the valid/ready operation/result channels
//              (sub=1 computes a - b, sub=0 computes a + b + ci)
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_rca_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  // Full stage record. The sum field holds valid chunks 0..k at stage k;
  // the a/b fields hold the effective operands, whose chunks above k are
  // still pending.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           stage_r   [STAGES];
  stage_t           stage_d_s [STAGES];
  logic             en_s;
  logic             in_fire_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  // The whole pipe moves as one unit; it only stalls when a result sits at
  // the output and downstream refuses it.
  assign en_s          = !stage_r[STAGES-1].ctl.valid || bus.out_ready;
  assign bus.in_ready  = en_s && !rst;
  assign in_fire_s     = bus.in_valid && bus.in_ready;

  // Subtraction is a + ~b + 1; ci only matters for addition.
  assign b_eff_s = bus.sub ? ~bus.b : bus.b;
  assign c0_s    = bus.sub ? 1'b1 : bus.ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src_s;
    logic [WIDTH-1:0] b_src_s;
    logic [WIDTH-1:0] sum_src_s;
    logic             cin_s;
    logic             valid_in_s;
    logic [CHUNK-1:0] s_chunk_s;
    logic             co_s;
    logic             c_msb_s;
    stage_t           nxt_s;

    if (k == 0) begin : g_first
      assign a_src_s    = bus.a;
      assign b_src_s    = b_eff_s;
      assign sum_src_s  = {WIDTH{1'b0}};
      assign cin_s      = c0_s;
      assign valid_in_s = in_fire_s;
    end else begin : g_next
      assign a_src_s    = stage_r[k-1].a;
      assign b_src_s    = stage_r[k-1].b;
      assign sum_src_s  = stage_r[k-1].sum;
      assign cin_s      = stage_r[k-1].ctl.carry;
      assign valid_in_s = stage_r[k-1].ctl.valid;
    end

    rca_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (a_src_s[k*CHUNK +: CHUNK]),
      .b     (b_src_s[k*CHUNK +: CHUNK]),
      .ci    (cin_s),
      .s     (s_chunk_s),
      .co    (co_s),
      .c_msb (c_msb_s)
    );

    // Next stage record: merge this chunk's sum into the delayed result bits.
    always_comb begin
      nxt_s                         = '0;
      nxt_s.ctl.valid               = valid_in_s;
      nxt_s.ctl.carry               = co_s;
      nxt_s.ctl.ovf                 = c_msb_s ^ co_s;
      nxt_s.a                       = a_src_s;
      nxt_s.b                       = b_src_s;
      nxt_s.sum                     = sum_src_s;
      nxt_s.sum[k*CHUNK +: CHUNK]   = s_chunk_s;
    end

    assign stage_d_s[k] = nxt_s;
  end

  // Stage registers: cleared by reset, advanced together on en, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= '0;
      end
    end else if (en_s) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= stage_d_s[k];
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= stage_r[k];
      end
    end
  end

  // Outputs come straight from the last stage register.
  assign bus.out_valid = stage_r[STAGES-1].ctl.valid;
  assign bus.s         = stage_r[STAGES-1].sum;
  assign bus.co        = stage_r[STAGES-1].ctl.carry;
  assign bus.ovf       = stage_r[STAGES-1].ctl.ovf;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Testbench for pipelined_rca_adder: a 16-bit/4-stage instance plus 4-bit
// instances with 1, 2 and 4 stages, each checked against an arithmetic
// reference model through a per-instance expected-result queue.
module tb_pipelined_rca_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_rca_adder_if #(.WIDTH(16)) m_if ();
  pipelined_rca_adder_if #(.WIDTH(4))  s1_if ();
  pipelined_rca_adder_if #(.WIDTH(4))  s2_if ();
  pipelined_rca_adder_if #(.WIDTH(4))  s4_if ();

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) u_m  (.clk(clk), .rst(rst), .bus(m_if.slave));
  pipelined_rca_adder #(.WIDTH(4),  .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .bus(s1_if.slave));
  pipelined_rca_adder #(.WIDTH(4),  .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(s2_if.slave));
  pipelined_rca_adder #(.WIDTH(4),  .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .bus(s4_if.slave));

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_in_cyc = 0;
  logic        f0, f1, f2, f4;
  logic        use_dir;
  logic [17:0] dir_exp;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] q4[$];

  // Expected {ovf, co, s} for a w-bit operation, from plain integer arithmetic.
  function automatic logic [17:0] ref_model(int w, int a, int b, logic ci, logic sub);
    int          mask, be, c0, full, s, msb;
    logic        co, ovf;
    logic [15:0] s16;
    mask = (1 << w) - 1;
    be   = sub ? (~b & mask) : (b & mask);
    c0   = sub ? 1 : (ci ? 1 : 0);
    full = (a & mask) + be + c0;
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    msb  = w - 1;
    ovf  = (((a >> msb) & 1) == ((be >> msb) & 1)) && (((s >> msb) & 1) != ((a >> msb) & 1));
    s16  = s[15:0];
    return {ovf, co, s16};
  endfunction

  task automatic chk(string tag, logic [17:0] obs, logic [17:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(string tag, logic have, logic [17:0] obs, logic [17:0] exp);
    total++;
    assert (have === 1'b1 && obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h pending=%0d", tag, obs, exp, have);
    end
  endtask

  // One clock: at the falling edge score outputs leaving and record operations
  // entering every instance, then step past the rising edge.
  task automatic tick();
    logic [17:0] e;
    logic        h;
    @(negedge clk);
    f0 = m_if.in_valid && m_if.in_ready;
    f1 = s1_if.in_valid && s1_if.in_ready;
    f2 = s2_if.in_valid && s2_if.in_ready;
    f4 = s4_if.in_valid && s4_if.in_ready;
    if (m_if.out_valid && m_if.out_ready) begin
      h = (q0.size() != 0);
      e = 18'h0;
      if (h) e = q0.pop_front();
      chk_pop("w16s4 result", h, {m_if.ovf, m_if.co, m_if.s}, e);
    end
    if (s1_if.out_valid && s1_if.out_ready) begin
      h = (q1.size() != 0);
      e = 18'h0;
      if (h) e = q1.pop_front();
      chk_pop("w4s1 result", h, {s1_if.ovf, s1_if.co, 12'h000, s1_if.s}, e);
    end
    if (s2_if.out_valid && s2_if.out_ready) begin
      h = (q2.size() != 0);
      e = 18'h0;
      if (h) e = q2.pop_front();
      chk_pop("w4s2 result", h, {s2_if.ovf, s2_if.co, 12'h000, s2_if.s}, e);
    end
    if (s4_if.out_valid && s4_if.out_ready) begin
      h = (q4.size() != 0);
      e = 18'h0;
      if (h) e = q4.pop_front();
      chk_pop("w4s4 result", h, {s4_if.ovf, s4_if.co, 12'h000, s4_if.s}, e);
    end
    if (f0) begin
      if (use_dir) q0.push_back(dir_exp);
      else q0.push_back(ref_model(16, int'(m_if.a), int'(m_if.b), m_if.ci, m_if.sub));
      last_in_cyc = cyc;
    end
    if (f1) q1.push_back(ref_model(4, int'(s1_if.a), int'(s1_if.b), s1_if.ci, s1_if.sub));
    if (f2) q2.push_back(ref_model(4, int'(s2_if.a), int'(s2_if.b), s2_if.ci, s2_if.sub));
    if (f4) q4.push_back(ref_model(4, int'(s4_if.a), int'(s4_if.b), s4_if.ci, s4_if.sub));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    m_if.in_valid   = 1'b0;
    s1_if.in_valid  = 1'b0;
    s2_if.in_valid  = 1'b0;
    s4_if.in_valid  = 1'b0;
    m_if.out_ready  = 1'b1;
    s1_if.out_ready = 1'b1;
    s2_if.out_ready = 1'b1;
    s4_if.out_ready = 1'b1;
    while ((q0.size() + q1.size() + q2.size() + q4.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain pending", 18'(q0.size() + q1.size() + q2.size() + q4.size()), 18'h0);
  endtask

  task automatic measure_latency(string tag);
    int n = 0;
    while (m_if.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 18'(cyc - last_in_cyc), 18'd4);
  endtask

  task automatic set_rand_main();
    m_if.a   = 16'($urandom);
    m_if.b   = 16'($urandom);
    m_if.ci  = 1'($urandom_range(0, 1));
    m_if.sub = 1'($urandom_range(0, 1));
  endtask

  task automatic send_dir(logic [15:0] a, logic [15:0] b, logic ci, logic sub, logic [17:0] exp);
    m_if.a        = a;
    m_if.b        = b;
    m_if.ci       = ci;
    m_if.sub      = sub;
    m_if.in_valid = 1'b1;
    use_dir       = 1'b1;
    dir_exp       = exp;
    tick();
    chk("directed accepted", 18'(f0), 18'h1);
    m_if.in_valid = 1'b0;
    use_dir       = 1'b0;
  endtask

  initial begin
    int          i;
    int          step;
    int          k1, k2, k4, guard;
    logic [17:0] held;

    rst     = 1'b1;
    use_dir = 1'b0;
    dir_exp = 18'h0;
    m_if.in_valid  = 1'b0; m_if.a  = 16'h0; m_if.b  = 16'h0; m_if.ci  = 1'b0; m_if.sub  = 1'b0; m_if.out_ready  = 1'b1;
    s1_if.in_valid = 1'b0; s1_if.a = 4'h0;  s1_if.b = 4'h0;  s1_if.ci = 1'b0; s1_if.sub = 1'b0; s1_if.out_ready = 1'b1;
    s2_if.in_valid = 1'b0; s2_if.a = 4'h0;  s2_if.b = 4'h0;  s2_if.ci = 1'b0; s2_if.sub = 1'b0; s2_if.out_ready = 1'b1;
    s4_if.in_valid = 1'b0; s4_if.a = 4'h0;  s4_if.b = 4'h0;  s4_if.ci = 1'b0; s4_if.sub = 1'b0; s4_if.out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    chk("reset out_valid", 18'(m_if.out_valid), 18'h0);
    chk("reset s/co/ovf", {m_if.ovf, m_if.co, m_if.s}, 18'h0);
    chk("reset in_ready", 18'(m_if.in_ready), 18'h0);
    chk("reset w4s1 out_valid", 18'(s1_if.out_valid), 18'h0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 18'(m_if.in_ready), 18'h1);

    // Directed arithmetic corner cases.
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    measure_latency("latency ffff+1");
    drain();
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    send_dir(16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    drain();

    // Six back-to-back operations with a three-cycle output stall.
    i    = 0;
    step = 0;
    held = 18'h0;
    set_rand_main();
    m_if.in_valid = 1'b1;
    while (i < 6 && step < 40) begin
      m_if.out_ready = !(step >= 5 && step <= 7);
      #1;
      if (step >= 5 && step <= 7) begin
        chk("stall in_ready", 18'(m_if.in_ready), 18'h0);
        if (step == 5) begin
          held = {m_if.ovf, m_if.co, m_if.s};
          chk("stall out_valid", 18'(m_if.out_valid), 18'h1);
        end else begin
          chk("stall hold", {m_if.ovf, m_if.co, m_if.s}, held);
        end
      end
      tick();
      if (f0) begin
        i++;
        set_rand_main();
      end
      step++;
    end
    m_if.in_valid = 1'b0;
    chk("stream issued", 18'(i), 18'd6);
    drain();

    // Random traffic with bubbles and back-pressure.
    repeat (150) begin
      set_rand_main();
      m_if.in_valid  = ($urandom_range(0, 3) != 0);
      m_if.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with two operations in flight.
    m_if.out_ready = 1'b1;
    set_rand_main();
    m_if.in_valid = 1'b1;
    tick();
    set_rand_main();
    tick();
    m_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    q0.delete();
    q1.delete();
    q2.delete();
    q4.delete();
    chk("midreset out_valid", 18'(m_if.out_valid), 18'h0);
    chk("midreset s/co/ovf", {m_if.ovf, m_if.co, m_if.s}, 18'h0);
    rst = 1'b0;
    set_rand_main();
    m_if.in_valid = 1'b1;
    tick();
    chk("post-reset accepted", 18'(f0), 18'h1);
    m_if.in_valid = 1'b0;
    measure_latency("latency after reset");
    drain();

    // Exhaustive 4-bit a, b, ci, sub on 1/2/4-stage instances, random out_ready.
    k1 = 0; k2 = 0; k4 = 0; guard = 0;
    while ((k1 < 1024 || k2 < 1024 || k4 < 1024) && guard < 20000) begin
      s1_if.in_valid = (k1 < 1024); s1_if.a = 4'(k1); s1_if.b = 4'(k1 >> 4);
      s1_if.ci = k1[8]; s1_if.sub = k1[9]; s1_if.out_ready = 1'($urandom_range(0, 1));
      s2_if.in_valid = (k2 < 1024); s2_if.a = 4'(k2); s2_if.b = 4'(k2 >> 4);
      s2_if.ci = k2[8]; s2_if.sub = k2[9]; s2_if.out_ready = 1'($urandom_range(0, 1));
      s4_if.in_valid = (k4 < 1024); s4_if.a = 4'(k4); s4_if.b = 4'(k4 >> 4);
      s4_if.ci = k4[8]; s4_if.sub = k4[9]; s4_if.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (f1) k1++;
      if (f2) k2++;
      if (f4) k4++;
      guard++;
    end
    chk("exhaustive issued", 18'(k1 + k2 + k4), 18'd3072);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
# pipelined_rca_adder

Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the team's 4-bit ripple-carry adder. The operand width is split into STAGES equal chunks, and the carry is registered between chunks, so arbitrarily wide adds close timing at one result per clock. A valid/ready handshake on both sides lets it sit between datapath blocks that can stall.

## Interface
- WIDTH, 16: operand/result width in bits; must be divisible by STAGES.
- STAGES, 4: pipeline depth, 1..WIDTH; CHUNK = WIDTH/STAGES bits are added per stage.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  a/b/ci/sub carry a valid operation.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- ci  in  1  carry-in, used only when sub=0.
- sub  in  1  1 = compute a - b, 0 = compute a + b + ci.
- out_valid  out  1  s/co/ovf hold a valid result.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  carry-out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operands:
  - sub=0: b_eff = b, c0 = ci.
  - sub=1: b_eff = ~b, c0 = 1 (ci ignored).
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry registered by stage k-1 (stage 0 uses c0).
  - Registers the CHUNK-bit partial sum, the carry out and a valid bit.
- Skew registers:
  - Operand chunks above k are delayed alongside the operation.
  - Result chunks below k are delayed alongside the operation.
  - The final stage therefore presents all WIDTH result bits aligned to the same operation.
- ovf is computed in the last stage from the carry into its MSB and its carry out.
- Handshake:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en && !rst.
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
- When en=0, every stage register, skew register and valid bit holds its value. No operation is lost, duplicated or reordered.
- Bubbles (in_valid=0 while en=1) enter the pipeline as valid=0 entries. They are not collapsed.
- Results are exactly (a + b_eff + c0) mod 2^(WIDTH+1): s holds the low WIDTH bits, co holds bit WIDTH.

## Timing
- Latency:
  - A transfer in on cycle t yields out_valid=1 on cycle t+STAGES if no stall occurs.
  - Each stall cycle adds one cycle of latency.
- Throughput: one operation per cycle while out_ready=1.
- Reset:
  - rst high at a clock edge clears all valid bits.
  - s=0, co=0, ovf=0 and out_valid=0 from the next cycle.
  - in_ready=0 while rst=1.
  - In-flight operations are discarded and never appear at the output.
- Outputs s/co/ovf are registered and remain stable while out_valid=1 && out_ready=0.
- Transfers in and out may occur in the same cycle.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.

## Structure
- Shared package adder_pkg:
  - Default WIDTH and STAGES constants.
  - Typedef of the per-stage record {valid, carry, partial sum, delayed a/b_eff chunks}.
  - The CHUNK derivation function.
- Sub-module rca_chunk:
  - Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
  - Outputs: sum, carry out and carry into MSB.
  - Instantiated once per stage via generate.
- The top level holds the stage registers, the skew registers and the handshake logic only.

## Test plan
All cases use WIDTH=16, STAGES=4 unless stated.
- 0xFFFF + 0x0001, ci=0, sub=0, out_ready=1 -> after 4 cycles s=0x0000, co=1, ovf=0.
- 0x7FFF + 0x0001, ci=0 -> s=0x8000, co=0, ovf=1. Then 0x1234 + 0x4321, ci=1 -> s=0x5556, co=0, ovf=0.
- sub: 0x0005 - 0x0007 -> s=0xFFFE, co=0, ovf=0. Then 0x8000 - 0x0001 -> s=0x7FFF, co=1, ovf=1.
- Stream 6 back-to-back operations, with out_ready=0 for 3 cycles mid-stream:
  - in_ready is low during the stall.
  - The outputs are held stable.
  - All 6 results arrive in order with none duplicated.
- Reset mid-flight: 2 operations in the pipe, rst for 1 cycle:
  - out_valid=0 and s=0 next cycle.
  - Neither result is ever emitted.
  - A new operation issued afterwards emerges 4 cycles later.
- WIDTH=4 with STAGES=1, 2 and 4: exhaustive a, b, ci, sub with random out_ready -> every result matches the reference model a + b_eff + c0.
